// File: rtl/sdrc_app_arb.sv
// ---------------------------------------------------------------------------
// sdrc_app_arb
//   Two-port round-robin arbiter placed in front of the SDRAM core application
//   interface. Two masters (e.g. a wishbone bridge and a DMA engine) share one
//   sdrc_core. A grant is held for a whole burst, from request accept through
//   the last write beat or last read beat. Only one transfer is ever in flight.
//
// Parameters
//   APP_AW  application address width
//   APP_DW  application data width
//   APP_BW  byte-enable width (APP_DW/8)
//   BL      burst length field width
//
// Ports
//   sdram_clk, sdram_resetn      clock (rising edge), async active-low reset
//   sdr_init_done                no new grant is issued while low
//   pN_req/_addr/_len/_wr_n      port request (held until pN_req_ack), wr_n=0 write
//   pN_req_ack                   request accepted by the core (1-cycle pulse)
//   pN_wr_data/_wr_en_n          port write data and active-low byte enables
//   pN_wr_next                   write beat consumed, present the next beat
//   pN_rd_valid/_last_rd         read beat valid / final read beat
//   pN_rd_data                   broadcast read data (qualify with pN_rd_valid)
//   app_req/_addr/_len/_wr_n     request towards the core; app_req_ack back
//   app_wr_data/_wr_en_n         muxed write data towards the core
//   app_wr_next_req/app_last_wr  core write beat strobe / final write beat
//   app_rd_valid/_last_rd/_data  core read beat strobe / final beat / data
//   arb_gnt                      one-hot current grant (00 when idle)
//   arb_busy                     arbiter is not idle
// ---------------------------------------------------------------------------
module sdrc_app_arb #(
    parameter int unsigned APP_AW = 26,
    parameter int unsigned APP_DW = 32,
    parameter int unsigned APP_BW = 4,
    parameter int unsigned BL     = 9
) (
    input  logic              sdram_clk,
    input  logic              sdram_resetn,
    input  logic              sdr_init_done,

    input  logic              p0_req,
    input  logic [APP_AW-1:0] p0_req_addr,
    input  logic [BL-1:0]     p0_req_len,
    input  logic              p0_req_wr_n,
    output logic              p0_req_ack,
    input  logic [APP_DW-1:0] p0_wr_data,
    input  logic [APP_BW-1:0] p0_wr_en_n,
    output logic              p0_wr_next,
    output logic              p0_rd_valid,
    output logic              p0_last_rd,
    output logic [APP_DW-1:0] p0_rd_data,

    input  logic              p1_req,
    input  logic [APP_AW-1:0] p1_req_addr,
    input  logic [BL-1:0]     p1_req_len,
    input  logic              p1_req_wr_n,
    output logic              p1_req_ack,
    input  logic [APP_DW-1:0] p1_wr_data,
    input  logic [APP_BW-1:0] p1_wr_en_n,
    output logic              p1_wr_next,
    output logic              p1_rd_valid,
    output logic              p1_last_rd,
    output logic [APP_DW-1:0] p1_rd_data,

    output logic              app_req,
    output logic [APP_AW-1:0] app_req_addr,
    output logic [BL-1:0]     app_req_len,
    output logic              app_req_wr_n,
    input  logic              app_req_ack,
    output logic [APP_DW-1:0] app_wr_data,
    output logic [APP_BW-1:0] app_wr_en_n,
    input  logic              app_wr_next_req,
    input  logic              app_last_wr,
    input  logic              app_rd_valid,
    input  logic              app_last_rd,
    input  logic [APP_DW-1:0] app_rd_data,

    output logic [1:0]        arb_gnt,
    output logic              arb_busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WR,
        ST_RD
    } state_t;

    state_t state;
    logic   gnt_sel;   // granted port index, valid outside ST_IDLE
    logic   ptr;       // last fully served port (the low-priority one)
    logic   nxt_sel;

    logic              sel_req;
    logic [APP_AW-1:0] sel_addr;
    logic [BL-1:0]     sel_len;
    logic              sel_wr_n;
    logic [APP_DW-1:0] sel_wr_data;
    logic [APP_BW-1:0] sel_wr_en_n;

    // Both requesting: the port that was not served last wins.
    // Single requester: it wins.
    always_comb begin
        if (p0_req && p1_req)
            nxt_sel = ~ptr;
        else
            nxt_sel = p1_req;
    end

    always_comb begin
        if (gnt_sel) begin
            sel_req     = p1_req;
            sel_addr    = p1_req_addr;
            sel_len     = p1_req_len;
            sel_wr_n    = p1_req_wr_n;
            sel_wr_data = p1_wr_data;
            sel_wr_en_n = p1_wr_en_n;
        end else begin
            sel_req     = p0_req;
            sel_addr    = p0_req_addr;
            sel_len     = p0_req_len;
            sel_wr_n    = p0_req_wr_n;
            sel_wr_data = p0_wr_data;
            sel_wr_en_n = p0_wr_en_n;
        end
    end

    // Grant FSM; arb_gnt/arb_busy are registered alongside the state.
    always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
        if (!sdram_resetn) begin
            state    <= ST_IDLE;
            gnt_sel  <= 1'b0;
            ptr      <= 1'b0;
            arb_gnt  <= '0;
            arb_busy <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (sdr_init_done && (p0_req || p1_req)) begin
                        gnt_sel  <= nxt_sel;
                        arb_gnt  <= nxt_sel ? 2'b10 : 2'b01;
                        arb_busy <= 1'b1;
                        state    <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // A withdrawn request releases the grant without
                    // counting as served, so the pointer is left alone.
                    if (!sel_req) begin
                        state    <= ST_IDLE;
                        arb_gnt  <= '0;
                        arb_busy <= 1'b0;
                    end else if (app_req_ack) begin
                        state <= sel_wr_n ? ST_RD : ST_WR;
                    end
                end
                ST_WR: begin
                    if (app_wr_next_req && app_last_wr) begin
                        state    <= ST_IDLE;
                        ptr      <= gnt_sel;
                        arb_gnt  <= '0;
                        arb_busy <= 1'b0;
                    end
                end
                ST_RD: begin
                    if (app_rd_valid && app_last_rd) begin
                        state    <= ST_IDLE;
                        ptr      <= gnt_sel;
                        arb_gnt  <= '0;
                        arb_busy <= 1'b0;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    arb_gnt  <= '0;
                    arb_busy <= 1'b0;
                end
            endcase
        end
    end

    // Core-side request/data muxing and port-side strobe steering. Only the
    // granted port ever sees ack/next/valid; everything else idles.
    always_comb begin
        app_req      = 1'b0;
        app_req_addr = '0;
        app_req_len  = '0;
        app_req_wr_n = 1'b1;
        app_wr_data  = '0;
        app_wr_en_n  = '1;
        p0_req_ack   = 1'b0;
        p1_req_ack   = 1'b0;
        p0_wr_next   = 1'b0;
        p1_wr_next   = 1'b0;
        p0_rd_valid  = 1'b0;
        p1_rd_valid  = 1'b0;
        p0_last_rd   = 1'b0;
        p1_last_rd   = 1'b0;
        case (state)
            ST_REQ: begin
                app_req      = sel_req;
                app_req_addr = sel_addr;
                app_req_len  = sel_len;
                app_req_wr_n = sel_wr_n;
                if (sel_req && app_req_ack) begin
                    if (gnt_sel) p1_req_ack = 1'b1;
                    else         p0_req_ack = 1'b1;
                end
            end
            ST_WR: begin
                app_wr_data = sel_wr_data;
                app_wr_en_n = sel_wr_en_n;
                if (gnt_sel) p1_wr_next = app_wr_next_req;
                else         p0_wr_next = app_wr_next_req;
            end
            ST_RD: begin
                if (gnt_sel) begin
                    p1_rd_valid = app_rd_valid;
                    p1_last_rd  = app_last_rd;
                end else begin
                    p0_rd_valid = app_rd_valid;
                    p0_last_rd  = app_last_rd;
                end
            end
            default: ;
        endcase
    end

    assign p0_rd_data = app_rd_data;
    assign p1_rd_data = app_rd_data;

endmodule
